// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with frame-synchronous commit of display values.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module seg_scan_display #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned CLK_DIV        = 50000,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value_i,
  input  logic [DIGITS-1:0]     dp_i,
  input  logic [DIGITS-1:0]     blank_i,
  input  logic                  load_i,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_tick
);

  localparam int unsigned PRE_W = $clog2(CLK_DIV);
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW}};
  localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW}};

  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shd_val_q, shd_val_d, act_val_q, act_val_d;
  logic [DIGITS-1:0]   shd_dp_q, shd_dp_d, act_dp_q, act_dp_d;
  logic [DIGITS-1:0]   shd_blank_q, shd_blank_d, act_blank_q, act_blank_d;
  logic                pending_q, pending_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                frame_tick_q, frame_tick_d;

  logic                slot_end_c, boundary_c;
  logic [DIGITS-1:0]   lz_c, blank_eff_c, onehot_c;
  logic                zero_run_c;
  logic [3:0]          nib_c;
  logic                sel_dp_c, sel_blank_c;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  // Scan timing, shadow capture and frame-boundary commit
  always_comb begin
    presc_d     = presc_q;
    idx_d       = idx_q;
    shd_val_d   = shd_val_q;
    shd_dp_d    = shd_dp_q;
    shd_blank_d = shd_blank_q;
    act_val_d   = act_val_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    pending_d   = pending_q;

    slot_end_c = (presc_q == PRE_MAX);
    boundary_c = slot_end_c && (idx_q == IDX_MAX);

    presc_d = slot_end_c ? '0 : presc_q + PRE_W'(1);
    if (slot_end_c) begin
      idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
    end

    // A load coinciding with the boundary goes straight to the active set
    if (load_i && boundary_c) begin
      act_val_d   = value_i;
      act_dp_d    = dp_i;
      act_blank_d = blank_i;
      pending_d   = 1'b0;
    end else if (load_i) begin
      shd_val_d   = value_i;
      shd_dp_d    = dp_i;
      shd_blank_d = blank_i;
      pending_d   = 1'b1;
    end else if (boundary_c && pending_q) begin
      act_val_d   = shd_val_q;
      act_dp_d    = shd_dp_q;
      act_blank_d = shd_blank_q;
      pending_d   = 1'b0;
    end
  end

  // Digit selection and segment decode for the registered outputs
  always_comb begin
    lz_c        = '0;
    zero_run_c  = 1'b1;
    nib_c       = 4'h0;
    sel_dp_c    = 1'b0;
    sel_blank_c = 1'b0;
    onehot_c    = '0;

`ifdef LZ_BLANK_EN
    // A lit dp breaks the zero run for its digit and everything below it
    for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
      zero_run_c = zero_run_c & (act_val_q[4*k +: 4] == 4'h0) & ~act_dp_q[k];
      lz_c[k]    = zero_run_c;
    end
`else
    zero_run_c = 1'b0;
`endif
    blank_eff_c = act_blank_q | lz_c;

    for (int k = 0; k < int'(DIGITS); k++) begin
      if (IDX_W'(k) == idx_q) begin
        nib_c       = act_val_q[4*k +: 4];
        sel_dp_c    = act_dp_q[k];
        sel_blank_c = blank_eff_c[k];
        onehot_c[k] = 1'b1;
      end
    end

    an_d         = sel_blank_c ? AN_OFF  : (AN_ACTIVE_LOW ? ~onehot_c : onehot_c);
    seg_d        = sel_blank_c ? SEG_OFF : (SEG_ACTIVE_LOW ? ~hex7(nib_c) : hex7(nib_c));
    dp_d         = sel_blank_c ? SEG_ACTIVE_LOW : (sel_dp_c ^ SEG_ACTIVE_LOW);
    frame_tick_d = boundary_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shd_val_q    <= '0;
      shd_dp_q     <= '0;
      shd_blank_q  <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= '0;
      pending_q    <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= SEG_ACTIVE_LOW;
      frame_tick_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shd_val_q    <= shd_val_d;
      shd_dp_q     <= shd_dp_d;
      shd_blank_q  <= shd_blank_d;
      act_val_q    <= act_val_d;
      act_dp_q     <= act_dp_d;
      act_blank_q  <= act_blank_d;
      pending_q    <= pending_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display (DIGITS=4, CLK_DIV=4, active-low outputs).
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value_i = 16'hDEAD;
  logic [3:0]  dp_i = 4'hA;
  logic [3:0]  blank_i = 4'h5;
  logic        load_i = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_vec = 0;
  int n_err = 0;

`ifdef LZ_BLANK_EN
  localparam logic [3:0] ZERO_BLK = 4'b1110;
  localparam logic [3:0] LZ7_BLK  = 4'b1110;
  localparam logic [3:0] LZ7D_BLK = 4'b1000;
`else
  localparam logic [3:0] ZERO_BLK = 4'b0000;
  localparam logic [3:0] LZ7_BLK  = 4'b0000;
  localparam logic [3:0] LZ7D_BLK = 4'b0000;
`endif
  localparam logic [27:0] SEGS_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] SEGS_1A2F = {7'h79, 7'h08, 7'h24, 7'h0E};
  localparam logic [27:0] SEGS_2222 = {7'h24, 7'h24, 7'h24, 7'h24};
  localparam logic [27:0] SEGS_8888 = {7'h00, 7'h00, 7'h00, 7'h00};
  localparam logic [27:0] SEGS_0007 = {7'h40, 7'h40, 7'h40, 7'h78};

  seg_scan_display #(
    .DIGITS(4), .CLK_DIV(4), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .value_i(value_i), .dp_i(dp_i), .blank_i(blank_i),
    .load_i(load_i), .an(an), .seg(seg), .dp(dp), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    load_i  = ld;
    value_i = v;
    dp_i    = d;
    blank_i = b;
  endtask

  // Checks one 16-cycle frame; optional loads are driven after cycle l1 / l2
  task automatic check_frame(input string name, input logic [27:0] segs, input logic [3:0] blk,
                             input logic [3:0] dpl, input int l1, input logic [15:0] v1,
                             input logic [3:0] d1, input logic [3:0] b1,
                             input int l2, input logic [15:0] v2);
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;
    int         d;
    for (int i = 0; i < 16; i++) begin
      tick();
      d       = i / 4;
      exp_an  = blk[d] ? 4'hF : ~(4'b0001 << d);
      exp_seg = blk[d] ? 7'h7F : segs[7*d +: 7];
      exp_dp  = blk[d] ? 1'b1 : ~dpl[d];
      check_eq($sformatf("%s an c%0d", name, i), 16'(an), 16'(exp_an));
      check_eq($sformatf("%s seg c%0d", name, i), 16'(seg), 16'(exp_seg));
      check_eq($sformatf("%s dp c%0d", name, i), 16'(dp), 16'(exp_dp));
      check_eq($sformatf("%s tick c%0d", name, i), 16'(frame_tick), 16'(i == 15));
      if (i == l1)      drive(1'b1, v1, d1, b1);
      else if (i == l2) drive(1'b1, v2, d1, b1);
      else              drive(1'b0, 16'hDEAD, 4'hA, 4'h5);
    end
  endtask

  task automatic check_reset_state(input string name);
    check_eq({name, " an"}, 16'(an), 16'h000F);
    check_eq({name, " seg"}, 16'(seg), 16'h007F);
    check_eq({name, " dp"}, 16'(dp), 16'h0001);
    check_eq({name, " tick"}, 16'(frame_tick), 16'h0000);
  endtask

  initial begin
    #12;
    check_reset_state("rst");
    reset = 1'b0;

    check_frame("f0", SEGS_ZERO, ZERO_BLK, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
    check_frame("f1", SEGS_ZERO, ZERO_BLK, 4'b0000, 3, 16'h1A2F, 4'h0, 4'h0, -1, 16'h0);
    check_frame("f2", SEGS_1A2F, 4'b0000, 4'b0000, 2, 16'h1111, 4'h0, 4'h0, 8, 16'h2222);
    check_frame("f3", SEGS_2222, 4'b0000, 4'b0000, 14, 16'h8888, 4'h0, 4'h0, -1, 16'h0);
    check_frame("f4", SEGS_8888, 4'b0000, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
    check_frame("f5", SEGS_8888, 4'b0000, 4'b0000, 5, 16'h1A2F, 4'b0001, 4'b0100, -1, 16'h0);
    check_frame("f6", SEGS_1A2F, 4'b0100, 4'b0001, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

    // Leave a load pending, then reset in the middle of a slot
    tick();
    drive(1'b1, 16'h5555, 4'h0, 4'h0);
    tick();
    drive(1'b0, 16'hDEAD, 4'hA, 4'h5);
    tick();
    tick();
    #2 reset = 1'b1;
    #1 check_reset_state("midrst");
    #4 reset = 1'b0;

    check_frame("r0", SEGS_ZERO, ZERO_BLK, 4'b0000, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);
    check_frame("r1", SEGS_ZERO, ZERO_BLK, 4'b0000, 3, 16'h0007, 4'h0, 4'h0, -1, 16'h0);
    check_frame("r2", SEGS_0007, LZ7_BLK, 4'b0000, 4, 16'h0007, 4'b0100, 4'h0, -1, 16'h0);
    check_frame("r3", SEGS_0007, LZ7D_BLK, 4'b0100, -1, 16'h0, 4'h0, 4'h0, -1, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
